// File: rtl/trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the trap sequencer and the machine-mode CSR file:
//   - CSR file op encodings (NOP/WRITE/SET/CLEAR)
//   - machine CSR addresses (mtvec, mscratch, mepc, mcause, mtval, mip)
//   - trap sequencer state encodings and state enum
//   - cause_encode(): 5-bit {interrupt, code} cause -> 32-bit mcause value
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

   localparam logic [1:0] CSR_OP_NOP   = 2'b00,
                          CSR_OP_WRITE = 2'b01,
                          CSR_OP_SET   = 2'b10,
                          CSR_OP_CLEAR = 2'b11;

   localparam logic [11:0] CSR_MTVEC    = 12'h305,
                           CSR_MSCRATCH = 12'h340,
                           CSR_MEPC     = 12'h341,
                           CSR_MCAUSE   = 12'h342,
                           CSR_MTVAL    = 12'h343,
                           CSR_MIP      = 12'h344;

   localparam logic [2:0] S_IDLE     = 3'd0,
                          S_W_MEPC   = 3'd1,
                          S_W_MCAUSE = 3'd2,
                          S_W_MTVAL  = 3'd3,
                          S_M_RD     = 3'd4,
                          S_M_CAP    = 3'd5,
                          S_REDIRECT = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE     = S_IDLE,
      ST_W_MEPC   = S_W_MEPC,
      ST_W_MCAUSE = S_W_MCAUSE,
      ST_W_MTVAL  = S_W_MTVAL,
      ST_M_RD     = S_M_RD,
      ST_M_CAP    = S_M_CAP,
      ST_REDIRECT = S_REDIRECT
   } trap_state_e;

   // Interrupt flag goes to bit 31, exception/interrupt code to the low bits.
   function automatic logic [31:0] cause_encode(input logic [4:0] cause);
      return {cause[4], 27'b0, cause[3:0]};
   endfunction

endpackage

// File: rtl/trap_ctrl_target.sv
// ---------------------------------------------------------------------------
// trap_target
// Combinational trap vector computation.
//   i_mtvec  [31:0] : current mtvec (base[31:2], mode[1:0])
//   i_cause  [4:0]  : {interrupt bit, code[3:0]}
//   o_target [31:0] : trap entry PC
// Vectored mode (mode 01) offsets interrupts by 4*code; exceptions and
// direct mode always use the base. Addition wraps modulo 2^32.
// ---------------------------------------------------------------------------
module trap_target
   import trap_ctrl_pkg::*;
(
   input  logic [31:0] i_mtvec,
   input  logic [4:0]  i_cause,
   output logic [31:0] o_target
);

   logic [31:0] w_base;
   logic [31:0] w_offset;
   logic        w_vectored;

   assign w_base     = {i_mtvec[31:2], 2'b00};
   assign w_vectored = (i_mtvec[1:0] == 2'b01) && i_cause[4];
   assign w_offset   = w_vectored ? {26'b0, i_cause[3:0], 2'b00} : 32'd0;
   assign o_target   = w_base + w_offset;

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap / mret sequencer. Accepts one request at a time from
// IDLE (exception > mret > interrupt), writes mepc/mcause[/mtval] through
// the CSR file port, or reads mepc back for mret, then issues a one-cycle
// fetch redirect.
//
// Build option: define TRAP_CTRL_MTVAL_EN to include the W_MTVAL state
// (mtval written with the faulting value). Without it mtval is never
// written, exc_tval is ignored and REDIRECT follows W_MCAUSE directly.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   exc_valid/cause/tval, cur_pc : exception request and its context
//   mret_valid        : mret request
//   irq_pending       : level interrupt request (cause = IRQ_CAUSE)
//   ack, busy         : request accepted this cycle / sequence in progress
//   csr_addr/op/wdata : CSR file command port
//   csr_rdata         : CSR file read data, one cycle after csr_addr
//   mtvec_rdata       : current mtvec
//   redirect_valid/pc : one-cycle fetch redirect and its registered target
// ---------------------------------------------------------------------------
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter logic [4:0] IRQ_CAUSE = 5'b10111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exc_valid,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_tval,
   input  logic [31:0] cur_pc,
   input  logic        mret_valid,
   input  logic        irq_pending,
   output logic        ack,
   output logic        busy,
   output logic [11:0] csr_addr,
   output logic [1:0]  csr_op,
   output logic [31:0] csr_wdata,
   input  logic [31:0] csr_rdata,
   input  logic [31:0] mtvec_rdata,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   trap_state_e r_state;
   logic [31:0] r_pc;
   logic [4:0]  r_cause;
   logic [31:0] r_redirect_pc;
   logic [31:0] w_target;
   logic        w_idle;
   logic        w_take_exc;
   logic        w_take_mret;
   logic        w_take_irq;

   // A request is only taken while out of reset, so ack never fires on a
   // cycle whose edge is going to be swallowed by reset.
   assign w_idle      = rst_n && (r_state == ST_IDLE);
   assign w_take_exc  = w_idle && exc_valid;
   assign w_take_mret = w_idle && !exc_valid && mret_valid;
   assign w_take_irq  = w_idle && !exc_valid && !mret_valid && irq_pending;

`ifdef TRAP_CTRL_MTVAL_EN
   logic [31:0] r_tval;
`else
   logic        w_unused_tval;
   assign w_unused_tval = ^exc_tval;
`endif

   trap_target u_trap_target (
      .i_mtvec  (mtvec_rdata),
      .i_cause  (r_cause),
      .o_target (w_target)
   );

   // Control: state and redirect target
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_redirect_pc <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_take_exc || w_take_irq) r_state <= ST_W_MEPC;
               else if (w_take_mret)         r_state <= ST_M_RD;
            end
            ST_W_MEPC:   r_state <= ST_W_MCAUSE;
`ifdef TRAP_CTRL_MTVAL_EN
            ST_W_MCAUSE: r_state <= ST_W_MTVAL;
            ST_W_MTVAL: begin
               r_state       <= ST_REDIRECT;
               r_redirect_pc <= w_target;
            end
`else
            ST_W_MCAUSE: begin
               r_state       <= ST_REDIRECT;
               r_redirect_pc <= w_target;
            end
`endif
            ST_M_RD:     r_state <= ST_M_CAP;
            ST_M_CAP: begin
               // mepc read data arrives the cycle after the M_RD address.
               r_state       <= ST_REDIRECT;
               r_redirect_pc <= csr_rdata;
            end
            ST_REDIRECT: r_state <= ST_IDLE;
            default:     r_state <= ST_IDLE;
         endcase
      end
   end

   // Trap context capture (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (w_take_exc || w_take_irq) begin
         r_pc    <= cur_pc;
         r_cause <= w_take_exc ? exc_cause : IRQ_CAUSE;
`ifdef TRAP_CTRL_MTVAL_EN
         r_tval  <= w_take_exc ? exc_tval : 32'd0;
`endif
      end
   end

   // CSR command decode
   always_comb begin
      csr_addr  = 12'h000;
      csr_op    = CSR_OP_NOP;
      csr_wdata = 32'd0;
      case (r_state)
         ST_W_MEPC: begin
            csr_addr  = CSR_MEPC;
            csr_op    = CSR_OP_WRITE;
            csr_wdata = r_pc;
         end
         ST_W_MCAUSE: begin
            csr_addr  = CSR_MCAUSE;
            csr_op    = CSR_OP_WRITE;
            csr_wdata = cause_encode(r_cause);
         end
`ifdef TRAP_CTRL_MTVAL_EN
         ST_W_MTVAL: begin
            csr_addr  = CSR_MTVAL;
            csr_op    = CSR_OP_WRITE;
            csr_wdata = r_tval;
         end
`endif
         ST_M_RD: csr_addr = CSR_MEPC;
         default: ;
      endcase
   end

   assign ack            = w_take_exc || w_take_mret || w_take_irq;
   assign busy           = (r_state != ST_IDLE);
   assign redirect_valid = (r_state == ST_REDIRECT);
   assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

   localparam logic [1:0] NOP = 2'b00;
   localparam logic [1:0] WR  = 2'b01;
`ifdef TRAP_CTRL_MTVAL_EN
   localparam int MTVAL_WRITES = 1;
`else
   localparam int MTVAL_WRITES = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_tval;
   logic [31:0] cur_pc;
   logic        mret_valid;
   logic        irq_pending;
   logic        ack;
   logic        busy;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic [31:0] mtvec_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_mtval_wr = 0;
   int          snap;
   logic [31:0] exp_rpc = 32'd0;

   always #5 clk = ~clk;

   trap_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .exc_valid      (exc_valid),
      .exc_cause      (exc_cause),
      .exc_tval       (exc_tval),
      .cur_pc         (cur_pc),
      .mret_valid     (mret_valid),
      .irq_pending    (irq_pending),
      .ack            (ack),
      .busy           (busy),
      .csr_addr       (csr_addr),
      .csr_op         (csr_op),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .mtvec_rdata    (mtvec_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // Counts every mtval write the DUT issues.
   always @(negedge clk)
      if (csr_op == WR && csr_addr == 12'h343) n_mtval_wr++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: check all outputs mid-cycle, then advance past the edge.
   task automatic cyc(input string tag, input logic a, input logic b, input logic [11:0] ad,
                      input logic [1:0] op, input logic [31:0] wd, input logic rv);
      @(negedge clk);
      check_val({tag, ".ack"},   {31'b0, ack},            {31'b0, a});
      check_val({tag, ".busy"},  {31'b0, busy},           {31'b0, b});
      check_val({tag, ".addr"},  {20'b0, csr_addr},       {20'b0, ad});
      check_val({tag, ".op"},    {30'b0, csr_op},         {30'b0, op});
      check_val({tag, ".wdata"}, csr_wdata,               wd);
      check_val({tag, ".rv"},    {31'b0, redirect_valid}, {31'b0, rv});
      check_val({tag, ".rpc"},   redirect_pc,             exp_rpc);
      @(posedge clk);
      #1;
   endtask

   // Cycles T+1 .. REDIRECT of an accepted trap.
   task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [31:0] mc,
                           input logic [31:0] tv, input logic [31:0] tgt);
      cyc({tag, ".mepc"},   1'b0, 1'b1, 12'h341, WR, pc, 1'b0);
      cyc({tag, ".mcause"}, 1'b0, 1'b1, 12'h342, WR, mc, 1'b0);
`ifdef TRAP_CTRL_MTVAL_EN
      cyc({tag, ".mtval"},  1'b0, 1'b1, 12'h343, WR, tv, 1'b0);
`endif
      exp_rpc = tgt;
      cyc({tag, ".redir"},  1'b0, 1'b1, 12'h000, NOP, 32'd0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; exc_valid = 1'b0; exc_cause = 5'd0; exc_tval = 32'd0; cur_pc = 32'd0;
      mret_valid = 1'b0; irq_pending = 1'b0; csr_rdata = 32'd0; mtvec_rdata = 32'd0;
      @(posedge clk);
      #1;
      cyc("rst0", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);

      // Request held during reset must not be acked.
      exc_valid = 1'b1; exc_cause = 5'h02; cur_pc = 32'h100; exc_tval = 32'hDEAD;
      mtvec_rdata = 32'h800;
      cyc("rst1", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);

      // Exception, direct mode
      rst_n = 1'b1;
      snap = n_mtval_wr;
      cyc("exc.T", 1'b1, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      exc_valid = 1'b0; cur_pc = 32'h0; exc_tval = 32'h0; exc_cause = 5'h0;
      trap_seq("exc", 32'h100, 32'h2, 32'hDEAD, 32'h800);
      cyc("exc.idle", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      check_val("exc.mtval_writes", n_mtval_wr - snap, MTVAL_WRITES);

      // Interrupt, vectored mode
      mtvec_rdata = 32'h801; cur_pc = 32'h2000; irq_pending = 1'b1;
      cyc("irq.T", 1'b1, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      irq_pending = 1'b0; cur_pc = 32'h0;
      trap_seq("irq", 32'h2000, 32'h8000_0007, 32'h0, 32'h81C);
      cyc("irq.idle", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);

      // mret: capture timing checked by changing rdata around M_CAP
      mret_valid = 1'b1; csr_rdata = 32'hBAD0;
      cyc("mret.T", 1'b1, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      mret_valid = 1'b0;
      cyc("mret.rd", 1'b0, 1'b1, 12'h341, NOP, 32'd0, 1'b0);
      csr_rdata = 32'h204;
      cyc("mret.cap", 1'b0, 1'b1, 12'h000, NOP, 32'd0, 1'b0);
      csr_rdata = 32'hBAD4;
      exp_rpc = 32'h204;
      cyc("mret.redir", 1'b0, 1'b1, 12'h000, NOP, 32'd0, 1'b1);
      cyc("mret.idle", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);

      // All three requests together; exception in vectored mode is not offset
      exc_valid = 1'b1; mret_valid = 1'b1; irq_pending = 1'b1;
      exc_cause = 5'h05; cur_pc = 32'h300; exc_tval = 32'h55; mtvec_rdata = 32'h1001;
      cyc("prio.T", 1'b1, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      exc_valid = 1'b0;
      trap_seq("prio", 32'h300, 32'h5, 32'h55, 32'h1000);
      cyc("prio.mretT", 1'b1, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      mret_valid = 1'b0; irq_pending = 1'b0;
      cyc("prio.rd", 1'b0, 1'b1, 12'h341, NOP, 32'd0, 1'b0);
      csr_rdata = 32'h440;
      cyc("prio.cap", 1'b0, 1'b1, 12'h000, NOP, 32'd0, 1'b0);
      exp_rpc = 32'h440;
      cyc("prio.redir", 1'b0, 1'b1, 12'h000, NOP, 32'd0, 1'b1);
      cyc("prio.idle", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);

      // Vectored target wraps past 2^32
      mtvec_rdata = 32'hFFFF_FFFD; cur_pc = 32'h40; irq_pending = 1'b1;
      cyc("wrap.T", 1'b1, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      irq_pending = 1'b0;
      trap_seq("wrap", 32'h40, 32'h8000_0007, 32'h0, 32'h18);
      cyc("wrap.idle", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);

      // Reset during W_MCAUSE abandons the sequence
      exc_valid = 1'b1; exc_cause = 5'h03; cur_pc = 32'h500; exc_tval = 32'h77;
      mtvec_rdata = 32'h900;
      cyc("rmid.T", 1'b1, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      exc_valid = 1'b0;
      cyc("rmid.mepc", 1'b0, 1'b1, 12'h341, WR, 32'h500, 1'b0);
      rst_n = 1'b0;
      cyc("rmid.mcause", 1'b0, 1'b1, 12'h342, WR, 32'h3, 1'b0);
      exp_rpc = 32'd0;
      snap = n_mtval_wr;
      cyc("rmid.rst", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++)
         cyc("rmid.after", 1'b0, 1'b0, 12'h000, NOP, 32'd0, 1'b0);
      check_val("rmid.mtval_writes", n_mtval_wr - snap, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter IRQ_CAUSE, default 5'b10111, mcause code {interrupt bit, code[3:0]} used when irq_pending is taken.
REQ-002 SHALL have ports as listed:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- exc_valid, input, 1, synchronous exception request; held high until ack.
- exc_cause, input, 5, {interrupt bit, code[3:0]}.
- exc_tval, input, 32, faulting value.
- cur_pc, input, 32, PC of the trapping or interrupted instruction.
- mret_valid, input, 1, mret request; held high until ack.
- irq_pending, input, 1, level interrupt request.
- ack, output, 1, request accepted this cycle.
- busy, output, 1, sequence in progress.
- csr_addr, output, 12, CSR file address.
- csr_op, output, 2, CSR file op (NOP/WRITE/SET/CLEAR encoding).
- csr_wdata, output, 32, CSR file write data.
- csr_rdata, input, 32, CSR file read data; valid one cycle after csr_addr is presented.
- mtvec_rdata, input, 32, current mtvec.
- redirect_valid, output, 1, one-cycle fetch redirect.
- redirect_pc, output, 32, redirect target, registered.

Function
REQ-003 SHALL implement these states: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, M_RD, M_CAP, REDIRECT.
REQ-004 In IDLE, priority SHALL be exc_valid > mret_valid > irq_pending; only the winner is acked (ack=1 for one cycle, T).
REQ-005 On trap accept at T, SHALL latch cur_pc, cause (exc_cause or IRQ_CAUSE), and tval (exc_tval; 0 for irq).
REQ-006 At T+1 (W_MEPC), SHALL drive csr_addr=0x341, op=WRITE, wdata=latched pc.
REQ-007 At T+2 (W_MCAUSE), SHALL drive addr=0x342, op=WRITE, wdata={cause[4],27'b0,cause[3:0]}.
REQ-008 At T+3 (W_MTVAL), SHALL drive addr=0x343, op=WRITE, wdata=latched tval; REDIRECT follows at T+4.
REQ-009 The trap target SHALL be {mtvec[31:2],2'b00}, plus 4*cause[3:0] when mtvec[1:0]==2'b01 and cause[4]=1; mtvec is sampled in the cycle before REDIRECT.
REQ-010 On mret accept at T: M_RD at T+1 (addr=0x341, op=NOP); M_CAP at T+2 captures csr_rdata as the target; REDIRECT at T+3.
REQ-011 REDIRECT SHALL assert redirect_valid for exactly one cycle and then return to IDLE; ack is not possible in REDIRECT.
REQ-012 Outside write states, csr_op SHALL be NOP; csr_addr SHALL be 0 except in M_RD.
REQ-013 busy SHALL be 1 in every state except IDLE; ack SHALL only occur in IDLE.
REQ-014 Requests arriving while busy SHALL be ignored, not queued; requesters hold them.
REQ-015 redirect_pc SHALL hold its last value outside REDIRECT; target arithmetic is 32-bit and wraps modulo 2^32.

Reset
REQ-016 When rst_n=0 at a clk edge, the block SHALL go to IDLE, even mid-sequence, abandoning any partial CSR writes.
REQ-017 Reset values SHALL be: ack=0, busy=0, csr_addr=0, csr_op=NOP, csr_wdata=0, redirect_valid=0, redirect_pc=0.

Configuration
REQ-018 TRAP_CTRL_MTVAL_EN defined: the W_MTVAL state exists (REQ-008).
REQ-019 TRAP_CTRL_MTVAL_EN undefined: W_MTVAL is absent, W_MCAUSE goes directly to REDIRECT at T+3, exc_tval is unused, and mtval is never written.

Structure
REQ-020 Shared package SHALL hold: CSR op encodings, CSR addresses (0x305, 0x340-0x344), the state enum, and the cause-encode helper shared with the CSR file.
REQ-021 Sub-module trap_target SHALL be the combinational mtvec/cause-to-target computation; everything else is flat.

Verification
REQ-022 exc_valid with cause=5'h02, cur_pc=0x100, tval=0xDEAD, mtvec=0x800 -> writes 0x341=0x100, 0x342=0x2, 0x343=0xDEAD; redirect_pc=0x800 at T+4.
REQ-023 irq_pending, mtvec=0x801 -> mcause=0x80000007, mtval=0, redirect_pc=0x81C.
REQ-024 mret_valid with csr_rdata=0x204 at T+2 -> M_RD addr=0x341 op=NOP, redirect_pc=0x204 at T+3.
REQ-025 exc_valid, mret_valid and irq_pending all high in the same cycle -> only the exception is acked; mret is acked in the IDLE cycle after REDIRECT.
REQ-026 rst_n low during W_MCAUSE -> next cycle all outputs at reset values; no 0x343 write and no redirect.
REQ-027 Build without TRAP_CTRL_MTVAL_EN -> the REQ-022 scenario redirects at T+3 and issues no 0x343 write.
